// File: rtl/wvb_dpram_drain_if.sv
// Stream port from the DPRAM drain toward the host/MCU interface FIFO.
// A beat transfers on a rising clk edge where out_valid && out_ready. Once out_valid
// is raised, out_data, out_last and out_valid stay unchanged until that beat
// transfers, and out_valid never depends on out_ready.
interface wvb_dpram_drain_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/wvb_dpram_drain.sv
// Drains one event from the 128-bit readout DPRAM onto a 16-bit stream, MSB lane first.
// Define WVB_DPRAM_DRAIN_CRC_EN to append a CRC-16-CCITT trailer word to every event.
module wvb_dpram_drain #(
  parameter int P_DPRAM_ADR_WIDTH = 8,
  parameter int P_RD_LAT          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dpram_run,
  input  logic [15:0]                  dpram_len,
  input  logic                         mode_cfg,
  output logic                         dpram_busy,
  output logic                         dpram_mode,
  output logic [P_DPRAM_ADR_WIDTH-1:0] rd_addr,
  input  logic [127:0]                 rd_data,
  wvb_dpram_drain_if.master            strm,
  output logic                         err_overrun,
  output logic                         err_len,
  output logic [2:0]                   dbg_state
);

  localparam int          LW  = P_DPRAM_ADR_WIDTH + 4;
  localparam int unsigned CAP = 32'd8 << P_DPRAM_ADR_WIDTH;
  localparam logic [2:0]  RD_LAT = 3'(P_RD_LAT);
`ifdef WVB_DPRAM_DRAIN_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
    S_CRC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state;
  logic [LW-1:0]  words_left;   // words not yet transferred, including the one on the bus
  logic [127:0]   cur_sh;       // current word, presented lane sitting in [127:112]
  logic [127:0]   nxt_word;
  logic [2:0]     lane;
  logic           rd_pend;
  logic [2:0]     rd_cnt;
  logic           len_over;
  logic [LW-1:0]  len_eff;

`ifdef WVB_DPRAM_DRAIN_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction
`endif

  always_comb begin
    len_over = {16'd0, dpram_len} > CAP;
    len_eff  = len_over ? LW'(CAP) : LW'({16'd0, dpram_len});
  end

  assign dbg_state = state;

  // The next word is requested as soon as the current one is loaded; with P_RD_LAT
  // at most 4 it always lands well before the 8 lanes of the current word run out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      dpram_busy     <= 1'b0;
      dpram_mode     <= 1'b0;
      rd_addr        <= '0;
      strm.out_data  <= '0;
      strm.out_valid <= 1'b0;
      strm.out_last  <= 1'b0;
      err_overrun    <= 1'b0;
      err_len        <= 1'b0;
      words_left     <= '0;
      cur_sh         <= '0;
      nxt_word       <= '0;
      lane           <= '0;
      rd_pend        <= 1'b0;
      rd_cnt         <= '0;
`ifdef WVB_DPRAM_DRAIN_CRC_EN
      crc            <= 16'hFFFF;
`endif
    end else begin
      if (rd_pend) rd_cnt <= rd_cnt + 3'd1;
      if (dpram_run && state != S_IDLE) err_overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (dpram_run) begin
            dpram_busy <= 1'b1;
            rd_addr    <= '0;
            words_left <= len_eff;
            lane       <= '0;
            if (len_over) err_len <= 1'b1;
`ifdef WVB_DPRAM_DRAIN_CRC_EN
            crc <= 16'hFFFF;
`endif
            if (len_eff == '0) begin
`ifdef WVB_DPRAM_DRAIN_CRC_EN
              strm.out_data  <= 16'hFFFF;
              strm.out_valid <= 1'b1;
              strm.out_last  <= 1'b1;
              state          <= S_CRC;
`else
              state <= S_DONE;
`endif
            end else begin
              rd_pend <= 1'b1;
              rd_cnt  <= '0;
              state   <= S_FETCH;
            end
          end else begin
            dpram_mode <= mode_cfg;
          end
        end

        S_FETCH: begin
          if (rd_pend && rd_cnt == RD_LAT) begin
            cur_sh         <= rd_data;
            strm.out_data  <= rd_data[127:112];
            strm.out_valid <= 1'b1;
            strm.out_last  <= !CRC_EN && (words_left == LW'(1));
            lane           <= '0;
            state          <= S_SHIFT;
            if (words_left > LW'(8)) begin
              rd_addr <= rd_addr + P_DPRAM_ADR_WIDTH'(1);
              rd_cnt  <= '0;
            end else begin
              rd_pend <= 1'b0;
            end
          end
        end

        S_SHIFT: begin
          if (rd_pend && rd_cnt == RD_LAT) begin
            nxt_word <= rd_data;
            rd_pend  <= 1'b0;
          end
          if (strm.out_valid && strm.out_ready) begin
            words_left <= words_left - LW'(1);
`ifdef WVB_DPRAM_DRAIN_CRC_EN
            crc <= crc16_upd(crc, strm.out_data);
`endif
            if (words_left == LW'(1)) begin
`ifdef WVB_DPRAM_DRAIN_CRC_EN
              strm.out_data <= crc16_upd(crc, strm.out_data);
              strm.out_last <= 1'b1;
              state         <= S_CRC;
`else
              strm.out_valid <= 1'b0;
              strm.out_last  <= 1'b0;
              state          <= S_DONE;
`endif
            end else if (lane == 3'd7) begin
              cur_sh        <= nxt_word;
              strm.out_data <= nxt_word[127:112];
              strm.out_last <= !CRC_EN && (words_left == LW'(2));
              lane          <= '0;
              if (words_left > LW'(9)) begin
                rd_addr <= rd_addr + P_DPRAM_ADR_WIDTH'(1);
                rd_pend <= 1'b1;
                rd_cnt  <= '0;
              end
            end else begin
              cur_sh        <= {cur_sh[111:0], 16'h0000};
              strm.out_data <= cur_sh[111:96];
              strm.out_last <= !CRC_EN && (words_left == LW'(2));
              lane          <= lane + 3'd1;
            end
          end
        end

        S_CRC: begin
          if (strm.out_valid && strm.out_ready) begin
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
            state          <= S_DONE;
          end
        end

        S_DONE: begin
          dpram_busy <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_dpram_drain.sv
// Directed bench for wvb_dpram_drain: DPRAM model, stream scoreboard, timing checks.
// Build with WVB_DPRAM_DRAIN_CRC_EN defined to expect the CRC trailer word.
module tb_wvb_dpram_drain;

  localparam int P_DPRAM_ADR_WIDTH = 8;
  localparam int P_RD_LAT          = 2;
  localparam int CAP_WORDS         = 2048;  // 8 lanes x 256 addresses
`ifdef WVB_DPRAM_DRAIN_CRC_EN
  localparam bit TB_CRC = 1'b1;
`else
  localparam bit TB_CRC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        dpram_run = 1'b0;
  logic [15:0] dpram_len = '0;
  logic        mode_cfg  = 1'b0;
  logic        dpram_busy, dpram_mode, err_overrun, err_len;
  logic [P_DPRAM_ADR_WIDTH-1:0] rd_addr;
  logic [127:0] rd_data;
  logic [2:0]   dbg_state;

  wvb_dpram_drain_if strm();

  wvb_dpram_drain #(
    .P_DPRAM_ADR_WIDTH(P_DPRAM_ADR_WIDTH),
    .P_RD_LAT(P_RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dpram_run(dpram_run),
    .dpram_len(dpram_len),
    .mode_cfg(mode_cfg),
    .dpram_busy(dpram_busy),
    .dpram_mode(dpram_mode),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .strm(strm),
    .err_overrun(err_overrun),
    .err_len(err_len),
    .dbg_state(dbg_state)
  );

  // DPRAM model: data for the address presented in cycle c is valid in cycle c+P_RD_LAT
  logic [127:0] mem [256];
  logic [P_DPRAM_ADR_WIDTH-1:0] addr_pipe [P_RD_LAT];
  always @(posedge clk) begin
    addr_pipe[0] <= rd_addr;
    for (int i = 1; i < P_RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign rd_data = mem[addr_pipe[P_RD_LAT-1]];

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];   // {out_last, out_data}
  int n_exp    = 0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Memory holds word index + 1 in every lane, so the stream of any event is 1, 2, 3, ...
  task automatic expect_event(input int len);
    int          n;
    logic [15:0] crc;
    logic [15:0] d;
    n   = (len > CAP_WORDS) ? CAP_WORDS : len;
    crc = 16'hFFFF;
    for (int w = 0; w < n; w++) begin
      d   = 16'(w + 1);
      crc = crc_model(crc, d);
      exp_q.push_back({(!TB_CRC && (w == n - 1)), d});
    end
    if (TB_CRC) exp_q.push_back({1'b1, crc});
    n_exp = exp_q.size();
  endtask

  // ---------------- driver / monitor ----------------
  task automatic run_event(input logic [15:0] len, input bit toggle_rdy, input int rst_at,
                           input int ovr_at, input bit flip_mode);
    int run_cyc, rise_cyc, fall_cyc, first_vld_cyc, last_xfer_cyc, rst_cyc;
    int xfer_cnt, vld_cycles;
    bit stall_prev, rst_fired, done;
    logic [16:0] stall_word, got;
    rise_cyc = -1; fall_cyc = -1; first_vld_cyc = -1; last_xfer_cyc = -1; rst_cyc = -1;
    xfer_cnt = 0; vld_cycles = 0; stall_prev = 0; rst_fired = 0; done = 0; stall_word = '0;

    @(posedge clk); #1;
    strm.out_ready = 1'b1;
    dpram_len      = len;
    dpram_run      = 1'b1;
    run_cyc        = cyc;
    @(posedge clk); #1;
    dpram_run = 1'b0;

    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      if (!rst) begin
        got = {strm.out_last, strm.out_data};
        if (stall_prev) begin
          check_eq("stall_valid", 32'(strm.out_valid), 32'd1);
          check_eq("stall_word", 32'(got), 32'(stall_word));
        end
        if (strm.out_valid) begin
          vld_cycles++;
          if (first_vld_cyc < 0) first_vld_cyc = cyc;
        end
        if (strm.out_valid && strm.out_ready) begin
          if (exp_q.size() == 0) check_eq("extra_word_count", 32'(xfer_cnt + 1), 32'(n_exp));
          else                   check_eq("word", 32'(got), 32'(exp_q.pop_front()));
          xfer_cnt++;
          last_xfer_cyc = cyc;
        end
        stall_prev = strm.out_valid && !strm.out_ready;
        stall_word = got;
      end else begin
        stall_prev = 1'b0;
      end
      if (dpram_busy && rise_cyc < 0) rise_cyc = cyc;
      if (!dpram_busy && rise_cyc >= 0) begin
        fall_cyc = cyc;
        done     = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (toggle_rdy) strm.out_ready = ~strm.out_ready;
        dpram_run = (ovr_at > 0) && (cyc == run_cyc + ovr_at);
        if (dpram_run) dpram_len = 16'd3;
        if (flip_mode && cyc == run_cyc + 2) mode_cfg = 1'b0;
        if (rst) rst = 1'b0;
        else if (rst_at > 0 && !rst_fired && xfer_cnt == rst_at) begin
          rst       = 1'b1;
          rst_fired = 1'b1;
          rst_cyc   = cyc;
        end
      end
    end

    if (!done) begin
      check_eq("busy_release_timeout", 32'(done), 32'd1);
    end else if (rst_at > 0) begin
      check_eq("rst_busy_next_cycle", 32'(fall_cyc), 32'(rst_cyc + 1));
      check_eq("rst_valid_low", 32'(strm.out_valid), 32'd0);
      check_eq("rst_words_before", 32'(xfer_cnt), 32'(rst_at));
      exp_q.delete();
    end else begin
      check_eq("busy_rise", 32'(rise_cyc), 32'(run_cyc + 1));
      check_eq("words_emitted", 32'(xfer_cnt), 32'(n_exp));
      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
      if (n_exp > 0) begin
        check_eq("first_valid_latency", 32'(first_vld_cyc - run_cyc), 32'(P_RD_LAT + 2));
        check_eq("busy_fall", 32'(fall_cyc), 32'(last_xfer_cyc + 2));
      end else begin
        check_eq("busy_fall_zero_len", 32'(fall_cyc), 32'(run_cyc + 2));
        check_eq("valid_cycles_zero_len", 32'(vld_cycles), 32'd0);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int a = 0; a < 256; a++)
      for (int l = 0; l < 8; l++)
        mem[a][(7 - l) * 16 +: 16] = 16'(a * 8 + l + 1);
    strm.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(dpram_busy), 32'd0);
    check_eq("rst_mode", 32'(dpram_mode), 32'd0);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("rst_out_data", 32'(strm.out_data), 32'd0);
    check_eq("rst_out_valid", 32'(strm.out_valid), 32'd0);
    check_eq("rst_out_last", 32'(strm.out_last), 32'd0);
    check_eq("rst_err_overrun", 32'(err_overrun), 32'd0);
    check_eq("rst_err_len", 32'(err_len), 32'd0);

    // nominal 16 words, then a partial final word
    expect_event(16); run_event(16'd16, 1'b0, 0, 0, 1'b0);
    expect_event(11); run_event(16'd11, 1'b0, 0, 0, 1'b0);

    // backpressure; mode_cfg drops mid-transfer but dpram_mode must hold until idle
    @(posedge clk); #1 mode_cfg = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("mode_idle_follow", 32'(dpram_mode), 32'd1);
    expect_event(16); run_event(16'd16, 1'b1, 0, 0, 1'b1);
    check_eq("mode_held_through_event", 32'(dpram_mode), 32'd1);
    @(negedge clk);
    check_eq("mode_follows_after_event", 32'(dpram_mode), 32'd0);

    // zero-length event
    expect_event(0); run_event(16'd0, 1'b0, 0, 0, 1'b0);

    // overrun mid-transfer
    check_eq("err_overrun_before", 32'(err_overrun), 32'd0);
    expect_event(16); run_event(16'd16, 1'b0, 0, 6, 1'b0);
    check_eq("err_overrun_set", 32'(err_overrun), 32'd1);

    // oversize length clamps to capacity
    check_eq("err_len_before", 32'(err_len), 32'd0);
    expect_event(65535); run_event(16'hFFFF, 1'b0, 0, 0, 1'b0);
    check_eq("err_len_set", 32'(err_len), 32'd1);
    check_eq("err_overrun_sticky", 32'(err_overrun), 32'd1);

    // reset after the 5th word, then a clean 8-word event from address 0
    expect_event(16); run_event(16'd16, 1'b0, 5, 0, 1'b0);
    check_eq("err_overrun_cleared", 32'(err_overrun), 32'd0);
    check_eq("err_len_cleared", 32'(err_len), 32'd0);
    check_eq("rd_addr_after_rst", 32'(rd_addr), 32'd0);
    expect_event(8); run_event(16'd8, 1'b0, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
